sprot_mchk: RTL and testbench
=============================

// Module: sprot_mchk
// PURPOSE
//  Multi-channel, parametrised start/phase protocol checker. Each channel sees
//  a start pulse followed by SEQ_LEN ordered phase strobes. Each strobe must
//  arrive within MAX_WAIT+1 cycles of the previous event. Reports per-channel
//  end-of-transfer, error pulse, error cause and a saturating error count.
//  Sits beside the protocol monitors, feeding status/IRQ logic.
// PARAMETERS
//  NUM_CH   4  number of independent channels
//  SEQ_LEN  2  phase strobes expected after start (>=1)
//  MAX_WAIT 0  extra idle cycles tolerated before each phase (0 = strict next-cycle)
//  CNT_W    8  width of per-channel error counter
// PORTS
//  clk       in   1              clock, all logic on posedge
//  rst_n     in   1              reset, synchronous, active-low
//  clr_cnt   in   1              synchronous clear of all error counters
//  start     in   NUM_CH         start strobe per channel
//  ph        in   NUM_CH*SEQ_LEN phase strobes; ch c phase i = ph[c*SEQ_LEN+i]
//  busy      out  NUM_CH         channel is mid-transfer (state != IDLE)
//  xfer_end  out  NUM_CH         1-cycle pulse: transfer terminated (ok or error)
//  prot_err  out  NUM_CH         1-cycle pulse with xfer_end when terminated by error
//  err_code  out  2*NUM_CH       cause, valid with prot_err: 0 none,1 timeout,2 restart
//  err_cnt   out  NUM_CH*CNT_W   saturating count of prot_err pulses per channel
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all FSMs IDLE; busy, xfer_end, prot_err,
//    err_code, err_cnt, idx, wait counter = 0. Reset mid-transfer aborts it.
//    No xfer_end is produced.
//  - Channels are fully independent. All outputs are registered.
//  - Per-channel FSM:
//    - IDLE.
//    - WAIT(idx, wcnt): idx 0..SEQ_LEN-1.
//    - wcnt 0..MAX_WAIT, width $clog2(MAX_WAIT+1) (min 1).
//  - IDLE: on start=1, go to WAIT(0,0). busy rises the next cycle.
//  - WAIT, ph[idx]=1:
//    - if idx<SEQ_LEN-1, go to WAIT(idx+1,0).
//    - else, success: next cycle xfer_end=1, prot_err=0, err_code=0, go IDLE.
//  - WAIT, ph[idx]=0, wcnt<MAX_WAIT: wcnt+1.
//  - WAIT, ph[idx]=0, wcnt==MAX_WAIT: timeout. Next cycle xfer_end=1,
//    prot_err=1, err_code=1, go IDLE.
//  - Phase strobes other than ph[idx] are ignored (not errors).
//  - start=1 in WAIT when the cycle does not terminate the transfer: restart
//    error. Next cycle xfer_end=1, prot_err=1, err_code=2, go IDLE. That start
//    is NOT accepted.
//  - start=1 in the same cycle as a terminating event (final phase or timeout):
//    - the termination is reported as above;
//    - the start is accepted, next state WAIT(0,0);
//    - busy stays 1, giving back-to-back transfers with no IDLE cycle.
//  - Latency, MAX_WAIT=0, SEQ_LEN=2: start@T, ph0@T+1, ph1@T+2 gives xfer_end=1
//    during cycle T+3.
//  - err_code holds its last value until the next termination. It is cleared
//    to 0 on success.
//  - err_cnt increments by 1 on the cycle prot_err is driven.
//    - It saturates at 2^CNT_W-1 (no wrap).
//    - clr_cnt=1 forces 0 and wins over a simultaneous increment.
// TESTING
//  1 Defaults. ch0: start@T, ph0@T+1, ph1@T+2 -> xfer_end[0]=1 @T+3,
//    prot_err=0, err_cnt[0]=0, busy[0]=1 for T+1..T+2.
//  2 MAX_WAIT=2: start@T, ph0@T+3, then no ph1 -> xfer_end=prot_err=1 @T+7,
//    err_code=1, err_cnt=1.
//  3 Defaults: start@T, start@T+1 (no ph0) -> prot_err=1, err_code=2 @T+2.
//    Then start@T+3 succeeds normally.
//  4 Back-to-back: final ph1 and start in the same cycle T -> xfer_end @T+1
//    with busy held 1. Second transfer completes normally.
//  5 CNT_W=2: 5 timeouts -> err_cnt 1,2,3,3,3. clr_cnt coincident with the
//    6th error -> err_cnt=0.
//  6 Reset mid-WAIT with channels 0-3 active: all outputs 0 next cycle, no
//    xfer_end. ch2 traffic does not affect ch1 state or counters.

Source files
------------

// File: rtl/sprot_mchk.sv
// Multi-channel start/phase protocol checker: each channel expects a start
// strobe followed by SEQ_LEN ordered phase strobes with bounded gaps.
module sprot_mchk #(
  parameter int NUM_CH   = 4,
  parameter int SEQ_LEN  = 2,
  parameter int MAX_WAIT = 0,
  parameter int CNT_W    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clr_cnt,
  input  logic [NUM_CH-1:0]           start,
  input  logic [NUM_CH*SEQ_LEN-1:0]   ph,
  output logic [NUM_CH-1:0]           busy,
  output logic [NUM_CH-1:0]           xfer_end,
  output logic [NUM_CH-1:0]           prot_err,
  output logic [2*NUM_CH-1:0]         err_code,
  output logic [NUM_CH*CNT_W-1:0]     err_cnt
);

  localparam int IDX_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int WC_W  = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(MAX_WAIT);
  localparam logic [WC_W-1:0]  WC_ONE   = WC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_RESTART = 2'd2;

  typedef enum logic {IDLE, WAIT} state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : gCh
    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WC_W-1:0]    wcnt_q, wcnt_d;
    logic               end_q, end_d;
    logic               err_q, err_d;
    logic [1:0]         code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEQ_LEN-1:0] phCh;
    logic               phHit;

    assign phCh  = ph[c*SEQ_LEN +: SEQ_LEN];
    assign phHit = phCh[idx_q];

    // Terminating events (final phase, timeout) take priority over a restart,
    // and a start coincident with one of them opens the next transfer.
    always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      end_d   = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      if (state_q == IDLE) begin
        if (start[c]) begin
          state_d = WAIT;
          idx_d   = '0;
          wcnt_d  = '0;
        end
      end else begin
        if (phHit && (idx_q == IDX_LAST)) begin
          end_d   = 1'b1;
          code_d  = CODE_NONE;
          state_d = start[c] ? WAIT : IDLE;
          idx_d   = '0;
          wcnt_d  = '0;
        end else if (!phHit && (wcnt_q == WC_LAST)) begin
          end_d   = 1'b1;
          err_d   = 1'b1;
          code_d  = CODE_TIMEOUT;
          state_d = start[c] ? WAIT : IDLE;
          idx_d   = '0;
          wcnt_d  = '0;
        end else if (start[c]) begin
          end_d   = 1'b1;
          err_d   = 1'b1;
          code_d  = CODE_RESTART;
          state_d = IDLE;
          idx_d   = '0;
          wcnt_d  = '0;
        end else if (phHit) begin
          idx_d  = idx_q + IDX_ONE;
          wcnt_d = '0;
        end else begin
          wcnt_d = wcnt_q + WC_ONE;
        end
      end

      cnt_d = cnt_q;
      if (clr_cnt) begin
        cnt_d = '0;
      end else if (err_d && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        idx_q   <= '0;
        wcnt_q  <= '0;
        end_q   <= 1'b0;
        err_q   <= 1'b0;
        code_q  <= CODE_NONE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        idx_q   <= idx_d;
        wcnt_q  <= wcnt_d;
        end_q   <= end_d;
        err_q   <= err_d;
        code_q  <= code_d;
        cnt_q   <= cnt_d;
      end
    end

    assign busy[c]                  = (state_q == WAIT);
    assign xfer_end[c]              = end_q;
    assign prot_err[c]              = err_q;
    assign err_code[2*c +: 2]       = code_q;
    assign err_cnt[c*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_sprot_mchk.sv
// Bench for sprot_mchk: two configurations checked every cycle against a
// transaction-level channel model, plus directed scenarios with literal values.
module tb_sprot_mchk;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       clrA, clrB;
  logic [3:0] startA;
  logic [7:0] phA;
  logic [1:0] startB;
  logic [3:0] phB;

  logic [3:0]  busyA, xeA, peA;
  logic [7:0]  codeA;
  logic [31:0] cntA;
  logic [1:0]  busyB, xeB, peB;
  logic [3:0]  codeB;
  logic [3:0]  cntB;

  sprot_mchk #(.NUM_CH(4), .SEQ_LEN(2), .MAX_WAIT(0), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .clr_cnt(clrA), .start(startA), .ph(phA),
    .busy(busyA), .xfer_end(xeA), .prot_err(peA), .err_code(codeA), .err_cnt(cntA)
  );

  sprot_mchk #(.NUM_CH(2), .SEQ_LEN(2), .MAX_WAIT(2), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .clr_cnt(clrB), .start(startB), .ph(phB),
    .busy(busyB), .xfer_end(xeB), .prot_err(peB), .err_code(codeB), .err_cnt(cntB)
  );

  // Channel view: is a transfer open, which phase is expected next, and how
  // many idle cycles have passed since the last accepted event.
  typedef struct {
    bit act;
    int pos;
    int el;
    bit xe;
    bit pe;
    int code;
    int cnt;
  } chan_t;

  chan_t mA[4];
  chan_t mB[2];

  int vectors = 0;
  int miscompares = 0;
  bit checkEn = 1'b0;

  function automatic chan_t stepCh(chan_t s, bit rstn, bit st, bit clr,
                                   logic [7:0] phv, int seqLen, int maxWait, int cntMax);
    chan_t n;
    bit hit;
    n = s;
    n.xe = 1'b0;
    n.pe = 1'b0;
    if (!rstn) begin
      n = '{default: 0};
      return n;
    end
    if (s.act) begin
      hit = phv[s.pos];
      if (hit && s.pos == seqLen - 1) begin
        n.xe = 1'b1; n.code = 0; n.act = st; n.pos = 0; n.el = 0;
      end else if (!hit && s.el == maxWait) begin
        n.xe = 1'b1; n.pe = 1'b1; n.code = 1; n.act = st; n.pos = 0; n.el = 0;
      end else if (st) begin
        n.xe = 1'b1; n.pe = 1'b1; n.code = 2; n.act = 1'b0; n.pos = 0; n.el = 0;
      end else if (hit) begin
        n.pos = s.pos + 1; n.el = 0;
      end else begin
        n.el = s.el + 1;
      end
    end else if (st) begin
      n.act = 1'b1; n.pos = 0; n.el = 0;
    end
    if (clr) n.cnt = 0;
    else if (n.pe && n.cnt < cntMax) n.cnt = n.cnt + 1;
    return n;
  endfunction

  // Advance the model with the inputs the DUTs sample on this edge.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++)
      mA[c] = stepCh(mA[c], rst_n, startA[c], clrA, 8'(phA[c*2 +: 2]), 2, 0, 255);
    for (int c = 0; c < 2; c++)
      mB[c] = stepCh(mB[c], rst_n, startB[c], clrB, 8'(phB[c*2 +: 2]), 2, 2, 3);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] eBusy, eXe, ePe, eCode, eCnt;

  // Every cycle, compare both instances against the model on the off edge.
  always @(negedge clk) begin
    if (checkEn) begin
      eBusy = '0; eXe = '0; ePe = '0; eCode = '0; eCnt = '0;
      for (int c = 0; c < 4; c++) begin
        eBusy[c] = mA[c].act;
        eXe[c]   = mA[c].xe;
        ePe[c]   = mA[c].pe;
        eCode[2*c +: 2] = 2'(mA[c].code);
        eCnt[8*c +: 8]  = 8'(mA[c].cnt);
      end
      checkOutput("A.busy", 32'(busyA), eBusy);
      checkOutput("A.xfer_end", 32'(xeA), eXe);
      checkOutput("A.prot_err", 32'(peA), ePe);
      checkOutput("A.err_code", 32'(codeA), eCode);
      checkOutput("A.err_cnt", cntA, eCnt);
      eBusy = '0; eXe = '0; ePe = '0; eCode = '0; eCnt = '0;
      for (int c = 0; c < 2; c++) begin
        eBusy[c] = mB[c].act;
        eXe[c]   = mB[c].xe;
        ePe[c]   = mB[c].pe;
        eCode[2*c +: 2] = 2'(mB[c].code);
        eCnt[2*c +: 2]  = 2'(mB[c].cnt);
      end
      checkOutput("B.busy", 32'(busyB), eBusy);
      checkOutput("B.xfer_end", 32'(xeB), eXe);
      checkOutput("B.prot_err", 32'(peB), ePe);
      checkOutput("B.err_code", 32'(codeB), eCode);
      checkOutput("B.err_cnt", 32'(cntB), eCnt);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus();
    startA = 4'($urandom & $urandom);
    phA    = 8'($urandom);
    startB = 2'($urandom & $urandom);
    phB    = 4'($urandom | $urandom);
    clrA   = ($urandom_range(0, 63) == 0);
    clrB   = ($urandom_range(0, 63) == 0);
    rst_n  = ($urandom_range(0, 299) != 0);
    step(1);
  endtask

  int expCnt[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; clrA = 1'b0; clrB = 1'b0;
    startA = '0; phA = '0; startB = '0; phB = '0;
    step(2);
    checkEn = 1'b1;
    checkOutput("reset.busyA", 32'(busyA), 32'd0);
    checkOutput("reset.cntA", cntA, 32'd0);
    rst_n = 1'b1;

    $display("[TB] ch0 nominal transfer");
    startA = 4'b0001; step(1);
    startA = 4'b0000; phA = 8'b01;
    checkOutput("T1.busy@T+1", 32'(busyA[0]), 32'd1);
    step(1);
    phA = 8'b10;
    checkOutput("T1.busy@T+2", 32'(busyA[0]), 32'd1);
    step(1);
    phA = 8'b00;
    checkOutput("T1.xfer_end", 32'(xeA[0]), 32'd1);
    checkOutput("T1.prot_err", 32'(peA[0]), 32'd0);
    checkOutput("T1.busy_after", 32'(busyA[0]), 32'd0);
    checkOutput("T1.err_cnt", 32'(cntA[7:0]), 32'd0);

    $display("[TB] timeout with MAX_WAIT=2");
    startB = 2'b01; step(1);
    startB = 2'b00; step(2);
    phB = 4'b0001; step(1);
    phB = 4'b0000; step(3);
    checkOutput("T2.xfer_end", 32'(xeB[0]), 32'd1);
    checkOutput("T2.prot_err", 32'(peB[0]), 32'd1);
    checkOutput("T2.err_code", 32'(codeB[1:0]), 32'd1);
    checkOutput("T2.err_cnt", 32'(cntB[1:0]), 32'd1);

    $display("[TB] restart then clean transfer");
    startB = 2'b10; step(1);
    step(1);
    startB = 2'b00;
    checkOutput("T3.prot_err", 32'(peB[1]), 32'd1);
    checkOutput("T3.err_code", 32'(codeB[3:2]), 32'd2);
    checkOutput("T3.busy", 32'(busyB[1]), 32'd0);
    step(1);
    startB = 2'b10; step(1);
    startB = 2'b00; phB = 4'b0100; step(1);
    phB = 4'b1000; step(1);
    phB = 4'b0000;
    checkOutput("T3.ok_end", 32'(xeB[1]), 32'd1);
    checkOutput("T3.ok_code", 32'(codeB[3:2]), 32'd0);
    checkOutput("T3.cnt_held", 32'(cntB[3:2]), 32'd1);

    $display("[TB] back-to-back transfers on ch2");
    startA = 4'b0100; step(1);
    startA = 4'b0000; phA = 8'b0001_0000; step(1);
    phA = 8'b0010_0000; startA = 4'b0100; step(1);
    startA = 4'b0000; phA = 8'b0001_0000;
    checkOutput("T4.end1", 32'(xeA[2]), 32'd1);
    checkOutput("T4.busy_held", 32'(busyA[2]), 32'd1);
    step(1);
    phA = 8'b0010_0000; step(1);
    phA = 8'b0000_0000;
    checkOutput("T4.end2", 32'(xeA[2]), 32'd1);
    checkOutput("T4.err2", 32'(peA[2]), 32'd0);
    checkOutput("T4.idle", 32'(busyA[2]), 32'd0);

    $display("[TB] counter saturation at CNT_W=2");
    clrB = 1'b1; step(1);
    clrB = 1'b0;
    for (int k = 0; k < 5; k++) begin
      startB = 2'b10; step(1);
      startB = 2'b00; step(3);
      checkOutput($sformatf("T5.cnt%0d", k), 32'(cntB[3:2]), 32'(expCnt[k]));
    end
    startB = 2'b10; step(1);
    startB = 2'b00; step(2);
    clrB = 1'b1; step(1);
    clrB = 1'b0;
    checkOutput("T5.clr_err", 32'(peB[1]), 32'd1);
    checkOutput("T5.clr_cnt", 32'(cntB[3:2]), 32'd0);

    $display("[TB] reset during active transfers");
    startA = 4'hF; step(1);
    startA = 4'h0;
    checkOutput("T6.all_busy", 32'(busyA), 32'hF);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1;
    checkOutput("T6.busy", 32'(busyA), 32'd0);
    checkOutput("T6.xfer_end", 32'(xeA), 32'd0);
    checkOutput("T6.code", 32'(codeA), 32'd0);

    $display("[TB] randomized traffic");
    repeat (4000) applyStimulus();
    rst_n = 1'b1; startA = '0; phA = '0; startB = '0; phB = '0;
    clrA = 1'b0; clrB = 1'b0;
    step(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
